// File: rtl/lut_interp_pkg.sv
// Shared definitions for the LUT-interpolated activation: width helpers, saturation and the
// default 16-entry sigmoid-like table.
package lut_interp_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;

    function automatic int unsigned frac_w(input int unsigned data_w, input int unsigned addr_w);
        return data_w - addr_w;
    endfunction

    // Clamp a signed value to the range of a w-bit two's-complement number.
    function automatic int sat(input int x, input int unsigned w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Index is the raw upper bits of z, so 0..7 cover z >= 0 and 8..15 cover z < 0.
    function automatic int default_lut(input int i);
        case (i & 15)
            0:       return 0;
            1:       return 8;
            2:       return 16;
            3:       return 48;
            4:       return 64;
            5:       return 80;
            6:       return 92;
            7:       return 100;
            8:       return -100;
            9:       return -92;
            10:      return -80;
            11:      return -64;
            12:      return -48;
            13:      return -32;
            14:      return -16;
            default: return -8;
        endcase
    endfunction

endpackage

// File: rtl/lut_interp_act_if.sv
// Sample/result handshake bus for lut_interp_act; the LUT write port exists only when
// LUT_INTERP_ACT_WRITE_EN is defined.
interface lut_interp_act_if #(
    parameter int unsigned DATA_W = 8
`ifdef LUT_INTERP_ACT_WRITE_EN
    ,
    parameter int unsigned ADDR_W = 4
`endif
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] z_value;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] a;
`ifdef LUT_INTERP_ACT_WRITE_EN
    logic                     wr_en;
    logic        [ADDR_W-1:0] wr_addr;
    logic signed [DATA_W-1:0] wr_data;
`endif

    modport master (
        output in_valid,
        output z_value,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a
`ifdef LUT_INTERP_ACT_WRITE_EN
        ,
        output wr_en,
        output wr_addr,
        output wr_data
`endif
    );

    modport slave (
        input  in_valid,
        input  z_value,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a
`ifdef LUT_INTERP_ACT_WRITE_EN
        ,
        input  wr_en,
        input  wr_addr,
        input  wr_data
`endif
    );

endinterface

// File: rtl/lut_interp_core.sv
// Interpolation arithmetic: S2 forms (next-base)*frac, S3 shifts, adds base and saturates.
module lut_interp_core
    import lut_interp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_DATA_W - DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next,
    input  logic        [FRAC_W-1:0] frac,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] a
);

    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + 1 + FRAC_W;

    logic signed [DIFF_W-1:0] diff;
    logic signed [FRAC_W:0]   frac_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;
    logic signed [DATA_W-1:0] a_d;

    logic                     s2_valid_q;
    logic signed [DATA_W-1:0] s2_base_q;
    logic signed [PROD_W-1:0] s2_prod_q;

    assign diff   = DIFF_W'(next) - DIFF_W'(base);
    assign frac_s = {1'b0, frac};
    assign prod   = PROD_W'(diff) * PROD_W'(frac_s);

    // Arithmetic shift floors toward -inf; the sum always fits PROD_W before clamping.
    assign sum = PROD_W'(s2_base_q) + (s2_prod_q >>> FRAC_W);
    assign a_d = DATA_W'(sat(32'(sum), DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_base_q  <= '0;
            s2_prod_q  <= '0;
            out_valid  <= 1'b0;
            a          <= '0;
        end else if (en) begin
            s2_valid_q <= in_valid;
            s2_base_q  <= base;
            s2_prod_q  <= prod;
            out_valid  <= s2_valid_q;
            a          <= a_d;
        end
    end

endmodule

// File: rtl/lut_interp_act.sv
// LUT-based piecewise-linear activation, 3-stage pipeline with ready/valid handshake.
// Define LUT_INTERP_ACT_WRITE_EN for a runtime-writable LUT (wr_en/wr_addr/wr_data on the bus).
module lut_interp_act
    import lut_interp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input logic            clk,
    input logic            rst,
    lut_interp_act_if.slave bus
);

    localparam int unsigned FRAC_W = frac_w(DATA_W, ADDR_W);
    localparam int unsigned LUT_N  = 1 << ADDR_W;
    // Last positive segment: interpolating past it would wrap onto the negative side.
    localparam logic [ADDR_W-1:0] TOP_IDX = {1'b0, {(ADDR_W - 1){1'b1}}};

    logic                     stall;
    logic                     accept;
    logic                     out_valid;
    logic signed [DATA_W-1:0] a;

    logic signed [DATA_W-1:0] lut [LUT_N];
    logic        [ADDR_W-1:0] idx;
    logic        [ADDR_W-1:0] idx_next;
    logic        [FRAC_W-1:0] frac;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] next;

    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_base_q;
    logic signed [DATA_W-1:0] s1_next_q;
    logic        [FRAC_W-1:0] s1_frac_q;

`ifdef LUT_INTERP_ACT_WRITE_EN
    logic signed [DATA_W-1:0] lut_q [LUT_N];

    // Write lands at the edge, so a sample accepted on that same edge still reads the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= DATA_W'(default_lut(i));
            end
        end else if (bus.wr_en) begin
            lut_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign lut = lut_q;
`else
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        assign lut[g] = DATA_W'(default_lut(g));
    end
`endif

    // Whole pipe freezes on back-pressure; a bubble does not open the input early.
    assign stall        = out_valid && !bus.out_ready;
    assign accept       = bus.in_valid && !stall;
    assign bus.in_ready = !stall;
    assign bus.out_valid = out_valid;
    assign bus.a        = a;

    assign idx      = bus.z_value[DATA_W-1:FRAC_W];
    assign frac     = bus.z_value[FRAC_W-1:0];
    assign idx_next = idx + ADDR_W'(1);
    assign base     = lut[idx];
    assign next     = (idx == TOP_IDX) ? base : lut[idx_next];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_base_q  <= '0;
            s1_next_q  <= '0;
            s1_frac_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_base_q <= base;
                s1_next_q <= next;
                s1_frac_q <= frac;
            end
        end
    end

    lut_interp_core #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .in_valid  (s1_valid_q),
        .base      (s1_base_q),
        .next      (s1_next_q),
        .frac      (s1_frac_q),
        .out_valid (out_valid),
        .a         (a)
    );

endmodule

// File: tb/tb_lut_interp_act.sv
// Self-checking bench for lut_interp_act: vector table, latency, back-pressure, reset flush,
// and (with LUT_INTERP_ACT_WRITE_EN) LUT write scenarios.
module tb_lut_interp_act;

    typedef struct {
        logic [7:0] z;
        int         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lut_interp_act_if #(.DATA_W(8)) bus ();

    lut_interp_act #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   n_out = 0;
    int   model_lut[16];
    int   dflt_lut[16] = '{0, 8, 16, 48, 64, 80, 92, 100,
                           -100, -92, -80, -64, -48, -32, -16, -8};
    logic hold_valid = 1'b0;
    int   hold_a = 0;
    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_act(input logic [7:0] z);
        int idx, frac, base, nxt, s;
        idx  = int'(z[7:4]);
        frac = int'(z[3:0]);
        base = model_lut[idx];
        nxt  = (idx == 7) ? base : model_lut[(idx + 1) % 16];
        s    = base + (((nxt - base) * frac) >>> 4);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Called at posedge+1; returns at the next posedge+1 after the sample was accepted.
    task automatic send(input logic [7:0] z, input int exp);
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.z_value  = z;
        #1;
        while (!bus.in_ready && tries < 50) begin
            @(posedge clk);
            #2;
            tries++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for z=%0h", z);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic measure_latency(input logic [7:0] z, input string name);
        int lat = 0;
        chk({name, "_in_ready"}, int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.z_value  = z;
        exp_q.push_back(ref_act(z));
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 10);
        chk(name, lat, 3);
    endtask

`ifdef LUT_INTERP_ACT_WRITE_EN
    task automatic lut_write(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = 8'(data);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        model_lut[addr] = data;
    endtask
`endif

    // Scoreboard and stall monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else begin
            if (hold_valid) begin
                chk("stall_hold_valid", int'(bus.out_valid), 1);
                chk("stall_hold_a", int'($signed(bus.a)), hold_a);
            end
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_in_ready", int'(bus.in_ready), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got a=%0d expected no output", $signed(bus.a));
                end else begin
                    chk("out_a", int'($signed(bus.a)), exp_q.pop_front());
                end
                n_out++;
            end
            hold_valid <= bus.out_valid && !bus.out_ready;
            hold_a     <= int'($signed(bus.a));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [7:0] zs;

        vecs[0]  = '{8'h28, 32};
        vecs[1]  = '{8'h7F, 100};
        vecs[2]  = '{8'h00, 0};
        vecs[3]  = '{8'h0F, 7};
        vecs[4]  = '{8'h80, -100};
        vecs[5]  = '{8'hF8, -4};
        vecs[6]  = '{8'h9C, -83};
        vecs[7]  = '{8'h70, 100};
        vecs[8]  = '{8'h35, 53};
        vecs[9]  = '{8'h6A, 97};
        vecs[10] = '{8'h4F, 79};
        model_lut = dflt_lut;

        bus.in_valid  = 1'b0;
        bus.z_value   = '0;
        bus.out_ready = 1'b1;
`ifdef LUT_INTERP_ACT_WRITE_EN
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_a", int'($signed(bus.a)), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;

        // Accept in first cycle after reset release; out_valid exactly 3 cycles later.
        measure_latency(8'h28, "latency_first");
        drain();

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].z, vecs[i].exp);
        end
        drain();

        // Back-pressure: 10 back-to-back samples, out_ready low for cycles 4..7.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    zs = 8'(i * 37 + 11);
                    send(zs, ref_act(zs));
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 4 && c <= 7);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_out - n0, 10);

        // Reset with three samples in flight.
        send(8'h35, 53);
        send(8'h6A, 97);
        send(8'h9C, -83);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_a", int'($signed(bus.a)), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure_latency(8'h4F, "latency_after_rst");
        drain();

`ifdef LUT_INTERP_ACT_WRITE_EN
        lut_write(2, 16);
        lut_write(3, 48);
        send(8'h28, 32);
        lut_write(7, 100);
        send(8'h7F, 100);
        lut_write(4, 127);
        lut_write(5, -128);
        send(8'h4F, ref_act(8'h4F));
        drain();

        // Write and accept on the same edge: the accepted sample sees the old entry.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 8'sd64;
        send(8'h20, 16);
        bus.wr_en = 1'b0;
        model_lut[2] = 64;
        send(8'h20, 64);
        drain();

        // Reset restores the default table.
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_lut = dflt_lut;
        send(8'h20, 16);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
